// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter : round-robin two-port sequencer for a single-port data memory
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     AReq,
  input  logic                     AWe,
  input  logic [ADDRESS_WIDTH-1:0] AAddr,
  input  logic [DATA_WIDTH-1:0]    AWData,
  output logic                     AAck,
  output logic [DATA_WIDTH-1:0]    ARData,
  input  logic                     BReq,
  input  logic                     BWe,
  input  logic [ADDRESS_WIDTH-1:0] BAddr,
  input  logic [DATA_WIDTH-1:0]    BWData,
  output logic                     BAck,
  output logic [DATA_WIDTH-1:0]    BRData,
  output logic [ADDRESS_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0]    MemWriteData,
  output logic                     MemWrite,
  input  logic [DATA_WIDTH-1:0]    MemData,
  output logic                     Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     ptr_q;    // 0: A wins a tie, 1: B wins a tie
  logic                     owner_q;  // 0: A, 1: B
  logic                     we_q;
  logic                     mem_write_q;
  logic                     a_ack_q;
  logic                     b_ack_q;
  logic                     busy_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic [DATA_WIDTH-1:0]    a_rdata_q;
  logic [DATA_WIDTH-1:0]    b_rdata_q;

  logic                     launch_d;
  logic                     grant_b_d;
  logic                     sel_we_d;
  logic [ADDRESS_WIDTH-1:0] sel_addr_d;
  logic [DATA_WIDTH-1:0]    sel_wdata_d;

  // In RESP only the non-owner may launch, so the owner cannot win twice in a row.
  always_comb begin
    launch_d  = 1'b0;
    grant_b_d = 1'b0;
    case (state_q)
      IDLE: begin
        launch_d  = AReq | BReq;
        grant_b_d = (AReq & BReq) ? ptr_q : BReq;
      end
      RESP: begin
        launch_d  = owner_q ? AReq : BReq;
        grant_b_d = ~owner_q;
      end
      default: ;
    endcase
    sel_we_d    = grant_b_d ? BWe    : AWe;
    sel_addr_d  = grant_b_d ? BAddr  : AAddr;
    sel_wdata_d = grant_b_d ? BWData : AWData;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        ACCESS: begin
          if (!we_q) begin
            if (owner_q) b_rdata_q <= MemData;
            else         a_rdata_q <= MemData;
          end
          a_ack_q <= ~owner_q;
          b_ack_q <= owner_q;
          state_q <= RESP;
          busy_q  <= 1'b1;
        end
        default: begin
          // IDLE, RESP and the unused encoding share the launch decision.
          if (launch_d) begin
            owner_q     <= grant_b_d;
            ptr_q       <= ~grant_b_d;
            we_q        <= sel_we_d;
            mem_write_q <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign AAck         = a_ack_q;
  assign BAck         = b_ack_q;
  assign ARData       = a_rdata_q;
  assign BRData       = b_rdata_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  // Reset blocks the strobe immediately so an aborted write never lands.
  assign MemWrite     = mem_write_q & ~Reset;
  assign Busy         = busy_q;

endmodule
`default_nettype wire
